// File: rtl/riscv32_5stage_pkg.sv
// Shared selection encodings, constants and IF-stage state encodings for the
// 5-stage RV32 core.
package riscv32_5stage_pkg;

  // pcSel encodings produced by the PC-select update logic
  localparam logic [1:0] PC_SEL_NEXT           = 2'd0;
  localparam logic [1:0] PC_SEL_JUMP_OR_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JALR           = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // IF fetch FSM: REQ issues, WAIT awaits a live response, KILL drops one
  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_KILL = 2'd2
  } ifState_t;

  // True when pcSel steers fetch away from the sequential path
  function automatic logic isRedirect(input logic [1:0] sel);
    return (sel == PC_SEL_JUMP_OR_BRANCH) || (sel == PC_SEL_JALR);
  endfunction

endpackage

// File: rtl/riscv32_5stage_next_pc_mux.sv
// Next-PC selection: sequential pc+4 or a word-aligned redirect target.
module riscv32_5stage_next_pc_mux
  import riscv32_5stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcSel,
  input  logic [31:0] jumpOrBranchTarget,
  input  logic [31:0] jalrTarget,
  output logic [31:0] nextPc,
  output logic        redirect
);

  // Select the next fetch address; redirect targets lose their low two bits
  always_comb begin
    nextPc   = pc + PC_STEP;
    redirect = 1'b0;
    case (pcSel)
      PC_SEL_JUMP_OR_BRANCH: begin
        nextPc   = jumpOrBranchTarget & PC_ALIGN_MASK;
        redirect = 1'b1;
      end
      PC_SEL_JALR: begin
        nextPc   = jalrTarget & PC_ALIGN_MASK;
        redirect = 1'b1;
      end
      default: begin
        // next and the reserved encoding both fall through sequentially
        nextPc   = pc + PC_STEP;
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv32_5stage_fetch_stage.sv
// IF stage: owns the PC, issues one outstanding imem request at a time,
// fills IF/ID, parks a response in a one-entry hold buffer during stalls and
// squashes in-flight fetches on redirect.
module riscv32_5stage_fetch_stage
  import riscv32_5stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcSel,
  input  logic [31:0] jumpOrBranchTarget,
  input  logic [31:0] jalrTarget,
  input  logic        stall,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        ifIdValid,
  output logic [31:0] ifIdPc,
  output logic [31:0] ifIdPcPlus4,
  output logic [31:0] ifIdInstr
);

  ifState_t    state;
  logic [31:0] pcReg;
  logic [31:0] reqPc;
  logic [31:0] nextPc;
  logic        redirect;
  logic        respLive;
  logic        reqValid;
  logic        holdValid;
  logic [31:0] holdPc;
  logic [31:0] holdInstr;

  riscv32_5stage_next_pc_mux u_nextPcMux (
    .pc                 (pcReg),
    .pcSel              (pcSel),
    .jumpOrBranchTarget (jumpOrBranchTarget),
    .jalrTarget         (jalrTarget),
    .nextPc             (nextPc),
    .redirect           (redirect)
  );

  // Request is offered only in REQ, never during a redirect or with a parked word
  always_comb begin
    reqValid = 1'b0;
    if (!rst && (state == IF_REQ) && !redirect && !holdValid) begin
      reqValid = 1'b1;
    end else begin
      reqValid = 1'b0;
    end
  end

  assign imemReqValid = reqValid;
  assign imemReqAddr  = pcReg;
  // Only a response to a request still wanted (WAIT, not KILL) carries data
  assign respLive     = imemRespValid && (state == IF_WAIT);

  // Fetch FSM and PC register; a redirect always overrides the sequential path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IF_REQ;
      pcReg <= RESET_PC;
      reqPc <= 32'h0000_0000;
    end else if (redirect) begin
      pcReg <= nextPc;
      // An outstanding request with no response yet must be drained in KILL
      if (((state == IF_WAIT) || (state == IF_KILL)) && !imemRespValid) begin
        state <= IF_KILL;
      end else begin
        state <= IF_REQ;
      end
    end else begin
      case (state)
        IF_REQ: begin
          if (reqValid && imemReqReady) begin
            reqPc <= pcReg;
            pcReg <= nextPc;
            state <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imemRespValid) begin
            state <= IF_REQ;
          end
        end
        IF_KILL: begin
          if (imemRespValid) begin
            state <= IF_REQ;
          end
        end
        default: begin
          state <= IF_REQ;
        end
      endcase
    end
  end

  // IF/ID register and hold buffer: redirect > stall > buffered > response > bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifIdValid   <= 1'b0;
      ifIdPc      <= 32'h0000_0000;
      ifIdPcPlus4 <= 32'h0000_0000;
      ifIdInstr   <= NOP_INSTR;
      holdValid   <= 1'b0;
      holdPc      <= 32'h0000_0000;
      holdInstr   <= NOP_INSTR;
    end else if (redirect) begin
      ifIdValid <= 1'b0;
      holdValid <= 1'b0;
    end else if (stall) begin
      if (respLive && ifIdValid) begin
        // IF/ID is occupied and frozen: park the word
        holdValid <= 1'b1;
        holdPc    <= reqPc;
        holdInstr <= imemRespData;
      end else if (respLive) begin
        // An empty IF/ID slot may accept the word even while stalled
        ifIdValid   <= 1'b1;
        ifIdPc      <= reqPc;
        ifIdPcPlus4 <= reqPc + PC_STEP;
        ifIdInstr   <= imemRespData;
      end
    end else if (holdValid) begin
      ifIdValid   <= 1'b1;
      ifIdPc      <= holdPc;
      ifIdPcPlus4 <= holdPc + PC_STEP;
      ifIdInstr   <= holdInstr;
      holdValid   <= 1'b0;
    end else if (respLive) begin
      ifIdValid   <= 1'b1;
      ifIdPc      <= reqPc;
      ifIdPcPlus4 <= reqPc + PC_STEP;
      ifIdInstr   <= imemRespData;
    end else begin
      ifIdValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv32_5stage_fetch_stage.sv
// Directed bench for the IF stage with a variable-latency imem responder and
// a flag-based behavioural model of fetch, hold and squash.
module tb_riscv32_5stage_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcSel;
  logic [31:0] jumpOrBranchTarget;
  logic [31:0] jalrTarget;
  logic        stall;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        ifIdValid;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdPcPlus4;
  logic [31:0] ifIdInstr;

  int testsRun    = 0;
  int testsFailed = 0;

  // behavioural model
  logic [31:0] mPc;
  logic        mOut;      // a request is in flight
  logic        mKilled;   // the in-flight request is to be discarded
  logic [31:0] mInPc;
  logic        mHold;
  logic [31:0] mHoldPc;
  logic [31:0] mHoldData;
  logic        mIfValid;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;

  // memory responder
  int          memLat;
  int          pendCnt;
  logic [31:0] pendAddr;

  riscv32_5stage_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .pcSel              (pcSel),
    .jumpOrBranchTarget (jumpOrBranchTarget),
    .jalrTarget         (jalrTarget),
    .stall              (stall),
    .imemReqValid       (imemReqValid),
    .imemReqAddr        (imemReqAddr),
    .imemReqReady       (imemReqReady),
    .imemRespValid      (imemRespValid),
    .imemRespData       (imemRespData),
    .ifIdValid          (ifIdValid),
    .ifIdPc             (ifIdPc),
    .ifIdPcPlus4        (ifIdPcPlus4),
    .ifIdInstr          (ifIdInstr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mOut = 1'b0; mKilled = 1'b0; mInPc = 32'd0;
    mHold = 1'b0; mHoldPc = 32'd0; mHoldData = 32'd0;
    mIfValid = 1'b0; mIfPc = 32'd0; mIfInstr = 32'h0000_0013;
  endtask

  task automatic modelLoad(input logic [31:0] pc, input logic [31:0] data);
    mIfValid = 1'b1; mIfPc = pc; mIfInstr = data;
  endtask

  // One clock: check request side, advance model, clock, check IF/ID, drive memory
  task automatic tick();
    logic        redir;
    logic        live;
    logic        hs;
    logic [31:0] addr;
    logic [31:0] tgt;
    #2;
    redir = (pcSel == 2'd1) || (pcSel == 2'd2);
    check1("reqValid", imemReqValid, !mOut && !redir && !mHold);
    check32("reqAddr", imemReqAddr, mPc);
    hs   = imemReqValid && imemReqReady;
    addr = imemReqAddr;
    tgt  = (pcSel == 2'd1) ? jumpOrBranchTarget : jalrTarget;
    tgt[1:0] = 2'b00;
    live = imemRespValid && mOut && !mKilled;
    if (redir) begin
      mPc = tgt; mIfValid = 1'b0; mHold = 1'b0;
      if (imemRespValid) begin
        mOut = 1'b0; mKilled = 1'b0;
      end else if (mOut) begin
        mKilled = 1'b1;
      end
    end else begin
      if (!mOut && !mHold && imemReqReady) begin
        mInPc = mPc; mPc = mPc + 32'd4; mOut = 1'b1; mKilled = 1'b0;
      end else if (imemRespValid && mOut) begin
        mOut = 1'b0; mKilled = 1'b0;
      end
      if (stall) begin
        if (live && mIfValid) begin
          mHold = 1'b1; mHoldPc = mInPc; mHoldData = imemRespData;
        end else if (live) begin
          modelLoad(mInPc, imemRespData);
        end
      end else if (mHold) begin
        modelLoad(mHoldPc, mHoldData); mHold = 1'b0;
      end else if (live) begin
        modelLoad(mInPc, imemRespData);
      end else begin
        mIfValid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check1("ifIdValid", ifIdValid, mIfValid);
    if (mIfValid) begin
      check32("ifIdPc", ifIdPc, mIfPc);
      check32("ifIdPcPlus4", ifIdPcPlus4, mIfPc + 32'd4);
      check32("ifIdInstr", ifIdInstr, mIfInstr);
    end
    imemRespValid = 1'b0;
    if (hs) begin
      pendCnt = memLat; pendAddr = addr;
    end
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        imemRespValid = 1'b1; imemRespData = memData(pendAddr);
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check1({tag, "_reqValid"}, imemReqValid, 1'b0);
    check32({tag, "_reqAddr"}, imemReqAddr, RESET_PC);
    check1({tag, "_ifIdValid"}, ifIdValid, 1'b0);
    check32({tag, "_ifIdPc"}, ifIdPc, 32'h0000_0000);
    check32({tag, "_ifIdPcPlus4"}, ifIdPcPlus4, 32'h0000_0000);
    check32({tag, "_ifIdInstr"}, ifIdInstr, 32'h0000_0013);
  endtask

  initial begin
    rst = 1'b1; pcSel = 2'd0; jumpOrBranchTarget = 32'd0; jalrTarget = 32'd0;
    stall = 1'b0; imemReqReady = 1'b1; imemRespValid = 1'b0; imemRespData = 32'd0;
    memLat = 1; pendCnt = 0; pendAddr = 32'd0;
    modelReset();
    #3;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // sequential fetch, zero-wait memory
    tick(); tick();
    check32("lit_pc100", ifIdPc, 32'h0000_0100);
    check32("lit_pc100_plus4", ifIdPcPlus4, 32'h0000_0104);
    check32("lit_instr100", ifIdInstr, 32'h5A5A_0113);
    tick(); tick();
    check32("lit_pc104", ifIdPc, 32'h0000_0104);

    // stall for 3 cycles while the 0x108 response arrives
    stall = 1'b1;
    tick(); tick(); tick();
    check32("lit_stall_hold_pc", ifIdPc, 32'h0000_0104);
    check1("lit_stall_no_req", imemReqValid, 1'b0);
    stall = 1'b0;
    tick();
    check32("lit_buffered_pc108", ifIdPc, 32'h0000_0108);
    check1("lit_buffered_valid", ifIdValid, 1'b1);

    // redirect while WAIT: 0x10C must be squashed
    memLat = 3;
    tick();
    pcSel = 2'd1; jumpOrBranchTarget = 32'h0000_2002;
    tick();
    pcSel = 2'd0;
    check32("lit_redirect_pc", imemReqAddr, 32'h0000_2000);
    check1("lit_kill_no_req", imemReqValid, 1'b0);
    tick(); tick();
    check1("lit_kill_bubble", ifIdValid, 1'b0);
    check1("lit_after_kill_req", imemReqValid, 1'b1);
    memLat = 1;
    tick(); tick();
    check32("lit_pc2000", ifIdPc, 32'h0000_2000);

    // jalr redirect beating stall with a live IF/ID
    stall = 1'b1; pcSel = 2'd2; jalrTarget = 32'h0000_3007; jumpOrBranchTarget = 32'h0000_5000;
    tick();
    pcSel = 2'd0; stall = 1'b0;
    check1("lit_jalr_squash", ifIdValid, 1'b0);
    check32("lit_jalr_pc", imemReqAddr, 32'h0000_3004);

    // redirect coincident with a response in WAIT, then wrap at the top
    tick();
    pcSel = 2'd1; jumpOrBranchTarget = 32'hFFFF_FFFF;
    tick();
    pcSel = 2'd0;
    check32("lit_wrap_target", imemReqAddr, 32'hFFFF_FFFC);
    check1("lit_same_cycle_drop", ifIdValid, 1'b0);
    tick(); tick();
    check32("lit_wrap_ifIdPc", ifIdPc, 32'hFFFF_FFFC);
    check32("lit_wrap_plus4", ifIdPcPlus4, 32'h0000_0000);
    check32("lit_wrap_reqAddr", imemReqAddr, 32'h0000_0000);

    // memory not ready for 5 cycles, then reset mid-WAIT
    imemReqReady = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    imemReqReady = 1'b1; memLat = 3;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    imemRespValid = 1'b0; pendCnt = 0; memLat = 1;
    modelReset();
    @(posedge clk); #1;
    rst = 1'b0;
    check32("lit_restart_addr", imemReqAddr, RESET_PC);
    tick(); tick();
    check32("lit_restart_pc", ifIdPc, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
